rename_map: RTL

Parametrised register rename unit with in-order commit and flush recovery. It maps architectural to physical registers using a speculative alias table (SRAT), a committed alias table (CRAT) and a circular FIFO free list. It sits between decode and dispatch: it renames one instruction per cycle, returns the superseded physical register to the ROB, and restores precise state on flush. It supersedes the single-table bitmap-scan renamer.

---
 rtl/rename_pkg.sv | 11 +
 rtl/phys_free_fifo.sv | 63 ++++++
 rtl/rename_map_checker.sv | 20 ++
 rtl/rename_map.sv | 105 ++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared defaults and types for the register rename unit.
// Width-derived types follow the default configuration.
package rename_pkg;
  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PHYS_REGS = 64;
  localparam int DEF_AW        = $clog2(DEF_ARCH_REGS);
  localparam int DEF_PW        = $clog2(DEF_PHYS_REGS);
  localparam int DEF_FL_DEPTH  = DEF_PHYS_REGS - DEF_ARCH_REGS;

  typedef logic [DEF_PW-1:0] phys_t;
endpackage

// File: rtl/phys_free_fifo.sv
// Circular free list of physical registers with speculative head,
// committed head and tail pointers; flush rewinds head to the committed head.
module phys_free_fifo
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = DEF_ARCH_REGS,
  parameter int PHYS_REGS = DEF_PHYS_REGS,
  localparam int PW       = $clog2(PHYS_REGS),
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pop,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          flush,
  output logic [PW-1:0] head_data,
  output logic [PW:0]   free_count
);

  logic [PW-1:0] ram_r [PHYS_REGS];
  logic [PW:0]   head_r;
  logic [PW:0]   commit_head_r;
  logic [PW:0]   tail_r;
  logic [PW:0]   commit_head_nxt_s;

  // Committed head after this cycle's commit, so a same-cycle flush lands on it
  always_comb begin
    commit_head_nxt_s = commit_head_r;
    if (push) begin
      commit_head_nxt_s = commit_head_r + (PW+1)'(1);
    end else begin
      commit_head_nxt_s = commit_head_r;
    end
  end

  // Free list storage and pointer state; reset preloads ARCH_REGS..PHYS_REGS-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        ram_r[i] <= (i < FL_DEPTH) ? PW'(ARCH_REGS + i) : PW'(0);
      end
      head_r        <= (PW+1)'(0);
      commit_head_r <= (PW+1)'(0);
      tail_r        <= (PW+1)'(FL_DEPTH);
    end else begin
      if (push) begin
        ram_r[tail_r[PW-1:0]] <= push_data;
        tail_r                <= tail_r + (PW+1)'(1);
      end
      commit_head_r <= commit_head_nxt_s;
      if (flush) begin
        head_r <= commit_head_nxt_s;
      end else if (pop) begin
        head_r <= head_r + (PW+1)'(1);
      end
    end
  end

  assign head_data  = ram_r[head_r[PW-1:0]];
  assign free_count = tail_r - head_r;

endmodule

// File: rtl/rename_map_checker.sv
// Protocol checks for the rename unit: a commit must never push into a full free list.
module rename_map_checker #(
  parameter int PW       = 6,
  parameter int FL_DEPTH = 32
) (
  input logic        clk,
  input logic        reset_n,
  input logic        commit_push,
  input logic [PW:0] free_count
);

  // Free list overflow means the ROB released a register twice
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(commit_push && (free_count == (PW+1)'(FL_DEPTH))))
        else $error("rename_map: commit into full free list");
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register rename unit: speculative and committed alias tables over a FIFO
// free list, one rename and one commit per cycle, precise flush recovery.
module rename_map
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = DEF_ARCH_REGS,
  parameter int PHYS_REGS = DEF_PHYS_REGS,
  localparam int AW       = $clog2(ARCH_REGS),
  localparam int PW       = $clog2(PHYS_REGS),
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rename_valid,
  output logic          rename_ready,
  input  logic          rd_write,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [PW-1:0] phys_rd,
  output logic [PW-1:0] old_phys_rd,
  output logic [PW-1:0] phys_rs1,
  output logic [PW-1:0] phys_rs2,
  input  logic          commit_valid,
  input  logic          commit_rd_write,
  input  logic [AW-1:0] commit_rd,
  input  logic [PW-1:0] commit_phys_rd,
  input  logic [PW-1:0] commit_old_phys,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  logic [PW-1:0] srat_r [ARCH_REGS];
  logic [PW-1:0] crat_r [ARCH_REGS];
  logic [PW-1:0] head_data_s;
  logic [PW:0]   free_count_s;
  logic          ready_s;
  logic          alloc_s;
  logic          commit_s;

  // Rename handshake and allocation decode; flush blocks firing
  always_comb begin
    ready_s  = (free_count_s != (PW+1)'(0)) && !flush;
    alloc_s  = rename_valid && ready_s && rd_write && (rd != AW'(0));
    commit_s = commit_valid && commit_rd_write && (commit_rd != AW'(0));
    if (alloc_s) begin
      phys_rd     = head_data_s;
      old_phys_rd = srat_r[rd];
    end else begin
      phys_rd     = PW'(0);
      old_phys_rd = PW'(0);
    end
  end

  assign rename_ready = ready_s;
  assign phys_rs1     = srat_r[rs1];
  assign phys_rs2     = srat_r[rs2];
  assign free_count   = free_count_s;

  // Alias tables; entry 0 is never written so x0 stays on phys 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        srat_r[i] <= PW'(i);
        crat_r[i] <= PW'(i);
      end
    end else begin
      if (commit_s) begin
        crat_r[commit_rd] <= commit_phys_rd;
      end
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          srat_r[i] <= (commit_s && (commit_rd == AW'(i))) ? commit_phys_rd : crat_r[i];
        end
      end else if (alloc_s) begin
        srat_r[rd] <= head_data_s;
      end
    end
  end

  phys_free_fifo #(
    .ARCH_REGS(ARCH_REGS),
    .PHYS_REGS(PHYS_REGS)
  ) u_free_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .pop        (alloc_s),
    .push       (commit_s),
    .push_data  (commit_old_phys),
    .flush      (flush),
    .head_data  (head_data_s),
    .free_count (free_count_s)
  );

  rename_map_checker #(
    .PW      (PW),
    .FL_DEPTH(FL_DEPTH)
  ) u_checker (
    .clk        (clk),
    .reset_n    (reset_n),
    .commit_push(commit_s),
    .free_count (free_count_s)
  );

endmodule
